// File: rtl/tc_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tc_tap_ctrl
// Description : Testchip IEEE 1149.1 TAP controller. 16-state TAP FSM,
//               4-bit IR, IDCODE / STATUS capture / persistent CFG data
//               registers and a 1-bit BYPASS register. CFG survives the
//               synchronous Test-Logic-Reset so the testchip keeps its
//               configuration while the PHY TAP is selected upstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_tap_ctrl #(
    parameter int                   IR_WIDTH   = 4,
    parameter int                   CFG_WIDTH  = 32,
    parameter logic [CFG_WIDTH-1:0] CFG_RESET  = {CFG_WIDTH{1'b0}},
    parameter logic [31:0]          IDCODE_VAL = 32'h1000_0CDB
) (
    input  logic                 tap_tck,
    input  logic                 tap_trst_n,
    input  logic                 tap_tms,
    input  logic                 tap_tdi,
    output logic                 tap_tdo,
    output logic                 tap_tdo_en,
    input  logic [31:0]          status_in,
    output logic [CFG_WIDTH-1:0] cfg_out,
    output logic [3:0]           tap_state
);

    typedef enum logic [3:0] {
        S_TLR     = 4'hF,
        S_RTI     = 4'hC,
        S_SEL_DR  = 4'h7,
        S_CAP_DR  = 4'h6,
        S_SH_DR   = 4'h2,
        S_EX1_DR  = 4'h1,
        S_PAU_DR  = 4'h3,
        S_EX2_DR  = 4'h0,
        S_UPD_DR  = 4'h5,
        S_SEL_IR  = 4'h4,
        S_CAP_IR  = 4'hE,
        S_SH_IR   = 4'hA,
        S_EX1_IR  = 4'h9,
        S_PAU_IR  = 4'hB,
        S_EX2_IR  = 4'h8,
        S_UPD_IR  = 4'hD
    } tap_state_t;

    // Instruction codes; anything not listed behaves as BYPASS
    localparam logic [IR_WIDTH-1:0] c_ins_idcode  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] c_ins_cfg     = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] c_ins_status  = IR_WIDTH'(3);
    // Value captured into the IR shift register (LSBs 01 as 1149.1 requires)
    localparam logic [IR_WIDTH-1:0] c_ir_capture  = IR_WIDTH'(1);

    tap_state_t           r_state;
    tap_state_t           w_state_next;
    logic [IR_WIDTH-1:0]  r_ir_shift;
    logic [IR_WIDTH-1:0]  r_ir;
    logic [31:0]          r_dr_id;
    logic [31:0]          r_dr_status;
    logic [CFG_WIDTH-1:0] r_dr_cfg;
    logic                 r_dr_bypass;
    logic [CFG_WIDTH-1:0] r_cfg;
    logic                 r_tdo;
    logic                 r_tdo_en;

    logic                 w_sel_idcode;
    logic                 w_sel_cfg;
    logic                 w_sel_status;
    logic                 w_sel_bypass;
    logic                 w_dr_lsb;
    logic                 w_tdo_next;
    logic                 w_tdo_en_next;

    assign w_sel_idcode = (r_ir == c_ins_idcode);
    assign w_sel_cfg    = (r_ir == c_ins_cfg);
    assign w_sel_status = (r_ir == c_ins_status);
    assign w_sel_bypass = !(w_sel_idcode || w_sel_cfg || w_sel_status);

    // TAP state register
    always_ff @(posedge tap_tck or negedge tap_trst_n) begin
        if (!tap_trst_n) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // 1149.1 next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_TLR:    w_state_next = tap_tms ? S_TLR    : S_RTI;
            S_RTI:    w_state_next = tap_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_state_next = tap_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_next = tap_tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_next = tap_tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_next = tap_tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_state_next = tap_tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_state_next = tap_tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_next = tap_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_state_next = tap_tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_next = tap_tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_next = tap_tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_next = tap_tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_state_next = tap_tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_state_next = tap_tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_next = tap_tms ? S_SEL_DR : S_RTI;
            default:  w_state_next = S_TLR;
        endcase
    end

    // Instruction register: capture / shift / update, reset to IDCODE in TLR
    always_ff @(posedge tap_tck or negedge tap_trst_n) begin
        if (!tap_trst_n) begin
            r_ir_shift <= '0;
            r_ir       <= c_ins_idcode;
        end else begin
            case (r_state)
                S_TLR:    r_ir       <= c_ins_idcode;
                S_CAP_IR: r_ir_shift <= c_ir_capture;
                S_SH_IR:  r_ir_shift <= {tap_tdi, r_ir_shift[IR_WIDTH-1:1]};
                S_UPD_IR: r_ir       <= r_ir_shift;
                default:  ;
            endcase
        end
    end

    // Data registers: only the one selected by the latched IR captures/shifts
    always_ff @(posedge tap_tck or negedge tap_trst_n) begin
        if (!tap_trst_n) begin
            r_dr_id     <= '0;
            r_dr_status <= '0;
            r_dr_cfg    <= '0;
            r_dr_bypass <= 1'b0;
        end else if (r_state == S_CAP_DR) begin
            if (w_sel_idcode) r_dr_id     <= IDCODE_VAL;
            if (w_sel_status) r_dr_status <= status_in;
            if (w_sel_cfg)    r_dr_cfg    <= r_cfg;
            if (w_sel_bypass) r_dr_bypass <= 1'b0;
        end else if (r_state == S_SH_DR) begin
            if (w_sel_idcode) r_dr_id     <= {tap_tdi, r_dr_id[31:1]};
            if (w_sel_status) r_dr_status <= {tap_tdi, r_dr_status[31:1]};
            if (w_sel_cfg)    r_dr_cfg    <= {tap_tdi, r_dr_cfg[CFG_WIDTH-1:1]};
            if (w_sel_bypass) r_dr_bypass <= tap_tdi;
        end
    end

    // CFG output: only trst_n resets it; TLR deliberately leaves it alone
    always_ff @(posedge tap_tck or negedge tap_trst_n) begin
        if (!tap_trst_n) begin
            r_cfg <= CFG_RESET;
        end else if ((r_state == S_UPD_DR) && w_sel_cfg) begin
            r_cfg <= r_dr_cfg;
        end
    end

    // Pick the LSB of the selected shift path for TDO
    always_comb begin
        w_dr_lsb      = r_dr_bypass;
        w_tdo_next    = 1'b0;
        w_tdo_en_next = 1'b0;
        if (w_sel_idcode) w_dr_lsb = r_dr_id[0];
        if (w_sel_status) w_dr_lsb = r_dr_status[0];
        if (w_sel_cfg)    w_dr_lsb = r_dr_cfg[0];
        if (r_state == S_SH_DR) begin
            w_tdo_next    = w_dr_lsb;
            w_tdo_en_next = 1'b1;
        end else if (r_state == S_SH_IR) begin
            w_tdo_next    = r_ir_shift[0];
            w_tdo_en_next = 1'b1;
        end
    end

    // TDO launched on the falling edge so it is stable at the next rising edge
    always_ff @(negedge tap_tck or negedge tap_trst_n) begin
        if (!tap_trst_n) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_en <= w_tdo_en_next;
        end
    end

    assign tap_tdo    = r_tdo;
    assign tap_tdo_en = r_tdo_en;
    assign cfg_out    = r_cfg;
    assign tap_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tc_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc_tap_ctrl
// Description : Directed self-checking bench for tc_tap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_tap_ctrl;

    localparam logic [31:0] c_idcode = 32'h1000_0CDB;

    logic        tap_tck;
    logic        tap_trst_n;
    logic        tap_tms;
    logic        tap_tdi;
    logic        tap_tdo;
    logic        tap_tdo_en;
    logic [31:0] status_in;
    logic [31:0] cfg_out;
    logic [3:0]  tap_state;

    int total = 0;
    int bad   = 0;

    tc_tap_ctrl dut (
        .tap_tck    (tap_tck),
        .tap_trst_n (tap_trst_n),
        .tap_tms    (tap_tms),
        .tap_tdi    (tap_tdi),
        .tap_tdo    (tap_tdo),
        .tap_tdo_en (tap_tdo_en),
        .status_in  (status_in),
        .cfg_out    (cfg_out),
        .tap_state  (tap_state)
    );

    initial tap_tck = 1'b0;
    always #5 tap_tck = ~tap_tck;

    // One TCK cycle: drive TMS/TDI, take the rising edge, sample TDO after the falling edge
    task automatic do_step(input logic tms, input logic tdi, output logic tdo_s);
        tap_tms = tms;
        tap_tdi = tdi;
        @(posedge tap_tck);
        @(negedge tap_tck);
        #1;
        tdo_s = tap_tdo;
    endtask

    // From RTI: full scan of n bits LSB-first, ends in Update-DR/IR
    task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] dout);
        logic s;
        dout = '0;
        do_step(1'b1, 1'b0, s);
        if (is_ir) do_step(1'b1, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        dout[0] = s;
        for (int i = 0; i < n; i++) begin
            do_step(i == n - 1, din[i], s);
            if (i < n - 1) dout[i + 1] = s;
        end
        do_step(1'b1, 1'b0, s);
    endtask

    task automatic test_reset();
        logic s;
        tap_trst_n = 1'b1;
        tap_tms    = 1'b1;
        tap_tdi    = 1'b0;
        status_in  = '0;
        #2 tap_trst_n = 1'b0;
        #1;
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=F", tap_state); end
        total++; if (tap_tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tap_tdo); end
        total++; if (tap_tdo_en !== 1'b0) begin bad++; $display("FAIL reset_tdo_en got=%b exp=0", tap_tdo_en); end
        total++; if (cfg_out !== 32'h0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", cfg_out); end
        repeat (2) @(negedge tap_tck);
        #1 tap_trst_n = 1'b1;
        do_step(1'b0, 1'b0, s);
        total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL reset_to_rti got=%h exp=C", tap_state); end
    endtask

    task automatic test_idcode_default();
        logic [31:0] d;
        logic s;
        scan(1'b0, 32, 32'h0, d);
        total++; if (tap_state !== 4'h5) begin bad++; $display("FAIL idcode_upd_state got=%h exp=5", tap_state); end
        do_step(1'b0, 1'b0, s);
        total++; if (d !== c_idcode) begin bad++; $display("FAIL idcode_default got=%h exp=%h", d, c_idcode); end
    endtask

    task automatic test_cfg_write();
        logic [31:0] d;
        logic s;
        scan(1'b1, 4, 32'h2, d);
        total++; if (d[3:0] !== 4'b0001) begin bad++; $display("FAIL ir_capture got=%b exp=0001", d[3:0]); end
        do_step(1'b0, 1'b0, s);
        scan(1'b0, 32, 32'hDEAD_BEEF, d);
        total++; if (cfg_out !== 32'h0) begin bad++; $display("FAIL cfg_before_upd got=%h exp=0", cfg_out); end
        total++; if (d !== 32'h0) begin bad++; $display("FAIL cfg_first_read got=%h exp=0", d); end
        do_step(1'b0, 1'b0, s);
        total++; if (cfg_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cfg_after_upd got=%h exp=DEADBEEF", cfg_out); end
        scan(1'b0, 32, 32'hDEAD_BEEF, d);
        do_step(1'b0, 1'b0, s);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cfg_readback got=%h exp=DEADBEEF", d); end
    endtask

    task automatic test_status();
        logic [31:0] d;
        logic s;
        scan(1'b1, 4, 32'h3, d);
        do_step(1'b0, 1'b0, s);
        status_in = 32'h1234_5678;
        scan(1'b0, 32, 32'hFFFF_FFFF, d);
        do_step(1'b0, 1'b0, s);
        status_in = 32'h0;
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL status_read got=%h exp=12345678", d); end
        total++; if (cfg_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL status_cfg_kept got=%h exp=DEADBEEF", cfg_out); end
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        logic s;
        scan(1'b1, 4, 32'h7, d);
        do_step(1'b0, 1'b0, s);
        // TDI sequence 1,0,1,1 -> TDO 0,1,0,1
        scan(1'b0, 4, 32'hD, d);
        do_step(1'b0, 1'b0, s);
        total++; if (d[3:0] !== 4'b1010) begin bad++; $display("FAIL bypass got=%b exp=1010", d[3:0]); end
        total++; if (cfg_out !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_cfg_kept got=%h exp=DEADBEEF", cfg_out); end
    endtask

    task automatic test_pause();
        logic [31:0] d;
        logic [31:0] din;
        logic s;
        scan(1'b1, 4, 32'h2, d);
        do_step(1'b0, 1'b0, s);
        scan(1'b0, 32, 32'h0F1E_2D3C, d);
        do_step(1'b0, 1'b0, s);
        total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pause_ref_read got=%h exp=DEADBEEF", d); end
        total++; if (cfg_out !== 32'h0F1E_2D3C) begin bad++; $display("FAIL pause_ref_cfg got=%h exp=0F1E2D3C", cfg_out); end
        din = 32'hCAFE_F00D;
        d   = '0;
        do_step(1'b1, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        d[0] = s;
        for (int i = 0; i < 32; i++) begin
            do_step((i == 11) || (i == 31), din[i], s);
            if (i == 11) begin
                do_step(1'b0, 1'b0, s);
                total++; if (tap_state !== 4'h3) begin bad++; $display("FAIL pause_state got=%h exp=3", tap_state); end
                total++; if (tap_tdo_en !== 1'b0) begin bad++; $display("FAIL pause_tdo_en got=%b exp=0", tap_tdo_en); end
                repeat (9) do_step(1'b0, 1'b0, s);
                do_step(1'b1, 1'b0, s);
                do_step(1'b0, 1'b0, s);
                total++; if (tap_tdo_en !== 1'b1) begin bad++; $display("FAIL resume_tdo_en got=%b exp=1", tap_tdo_en); end
                d[12] = s;
            end else if (i < 31) begin
                d[i + 1] = s;
            end
        end
        do_step(1'b1, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        total++; if (d !== 32'h0F1E_2D3C) begin bad++; $display("FAIL pause_read got=%h exp=0F1E2D3C", d); end
        total++; if (cfg_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL pause_cfg got=%h exp=CAFEF00D", cfg_out); end
    endtask

    task automatic test_tlr_persist();
        logic [31:0] d;
        logic s;
        do_step(1'b1, 1'b0, s);
        do_step(1'b1, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        total++; if (tap_state !== 4'hA) begin bad++; $display("FAIL shir_state got=%h exp=A", tap_state); end
        total++; if (tap_tdo_en !== 1'b1) begin bad++; $display("FAIL shir_tdo_en got=%b exp=1", tap_tdo_en); end
        repeat (5) do_step(1'b1, 1'b0, s);
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL tlr_state got=%h exp=F", tap_state); end
        total++; if (cfg_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL tlr_cfg got=%h exp=CAFEF00D", cfg_out); end
        do_step(1'b0, 1'b0, s);
        scan(1'b0, 32, 32'h0, d);
        do_step(1'b0, 1'b0, s);
        total++; if (d !== c_idcode) begin bad++; $display("FAIL tlr_ir_idcode got=%h exp=%h", d, c_idcode); end
        total++; if (cfg_out !== 32'hCAFE_F00D) begin bad++; $display("FAIL tlr_cfg_after got=%h exp=CAFEF00D", cfg_out); end
    endtask

    task automatic test_trst_mid_shift();
        logic [31:0] d;
        logic s;
        scan(1'b1, 4, 32'h2, d);
        do_step(1'b0, 1'b0, s);
        scan(1'b0, 32, 32'hA5A5_A5A5, d);
        do_step(1'b0, 1'b0, s);
        total++; if (cfg_out !== 32'hA5A5_A5A5) begin bad++; $display("FAIL trst_pre_cfg got=%h exp=A5A5A5A5", cfg_out); end
        do_step(1'b1, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        do_step(1'b0, 1'b0, s);
        repeat (5) do_step(1'b0, 1'b1, s);
        #2 tap_trst_n = 1'b0;
        #1;
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL trst_state got=%h exp=F", tap_state); end
        total++; if (tap_tdo !== 1'b0) begin bad++; $display("FAIL trst_tdo got=%b exp=0", tap_tdo); end
        total++; if (tap_tdo_en !== 1'b0) begin bad++; $display("FAIL trst_tdo_en got=%b exp=0", tap_tdo_en); end
        total++; if (cfg_out !== 32'h0) begin bad++; $display("FAIL trst_cfg got=%h exp=0", cfg_out); end
        @(negedge tap_tck);
        #1 tap_trst_n = 1'b1;
        do_step(1'b0, 1'b0, s);
        total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL trst_rti got=%h exp=C", tap_state); end
        scan(1'b0, 32, 32'h0, d);
        do_step(1'b0, 1'b0, s);
        total++; if (d !== c_idcode) begin bad++; $display("FAIL trst_idcode got=%h exp=%h", d, c_idcode); end
    endtask

    initial begin
        test_reset();
        test_idcode_default();
        test_cfg_write();
        test_status();
        test_bypass();
        test_pause();
        test_tlr_persist();
        test_trst_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/tc_tap_ctrl.md
# tc_tap_ctrl

Testchip IEEE 1149.1 TAP controller, sitting directly downstream of the testchip TAP IO mux. It consumes the shared TCK/TRST_N/TDI and the testchip-specific TMS, and returns the testchip TDO. It implements the 16-state TAP FSM, a 4-bit IR and three data registers: IDCODE, STATUS capture and a persistent CFG register driving testchip configuration. When the mux selects the PHY TAP, TMS is held at 1; this block then parks in Test-Logic-Reset and keeps CFG intact.

## Interface
- IR_WIDTH, 4, instruction register width
- CFG_WIDTH, 32, width of CFG data register / cfg_out
- CFG_RESET, {CFG_WIDTH{1'b0}}, cfg_out value after tap_trst_n
- IDCODE_VAL, 32'h1000_0CDB, IDCODE value; bit0 must be 1
- tap_tck  input  1  test clock; the only clock; posedge for state/shift, negedge for TDO
- tap_trst_n  input  1  asynchronous active-low reset
- tap_tms  input  1  TMS from mux (mux_tc_tap_tms)
- tap_tdi  input  1  TDI from mux
- tap_tdo  output  1  TDO to mux (mux_tc_tap_tdo)
- tap_tdo_en  output  1  high while in Shift-DR/Shift-IR (negedge-aligned)
- status_in  input  32  testchip status, sampled in Capture-DR under STATUS
- cfg_out  output  CFG_WIDTH  testchip configuration
- tap_state  output  4  current FSM state encoding (debug)

## Operation
- State encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Transitions per 1149.1 (TMS=1/0): TLR→TLR/RTI; RTI→SelDR/RTI; SelDR→SelIR/CapDR; CapDR→Ex1DR/ShDR; ShDR→Ex1DR/ShDR; Ex1DR→UpdDR/PauseDR; PauseDR→Ex2DR/PauseDR; Ex2DR→UpdDR/ShDR; UpdDR→SelDR/RTI; SelIR→TLR/CapIR; IR branch mirrors DR branch.
- Five consecutive TMS=1 clocks reach TLR from any state.
- Instructions: 4'b0001 IDCODE, 4'b0010 CFG, 4'b0011 STATUS, 4'b1111 BYPASS, all others → BYPASS.
- IR: shift register + latched IR. CapIR loads shift reg with 4'b0001; ShIR shifts right, tap_tdi enters the MSB, LSB goes to TDO; UpdIR copies shift reg into latched IR.
- DR selected by the latched IR:
  - CapDR loads IDCODE_VAL, cfg_out, status_in, or 1'b0 for BYPASS.
  - ShDR shifts LSB-first, TDI into MSB; BYPASS is 1 bit.
  - UpdDR under CFG loads cfg_out from the shift reg; other UpdDRs have no effect.
- TLR (sync): latched IR := IDCODE; cfg_out is NOT altered (persists while PHY TAP selected).
- tap_trst_n low (async): FSM := TLR, IR := IDCODE, all shift regs := 0, cfg_out := CFG_RESET.

## Timing
- Reset values: tap_state=F, tap_tdo=0, tap_tdo_en=0, cfg_out=CFG_RESET, IR=0001.
- FSM, shift regs, IR and cfg_out update on posedge tap_tck.
- tap_tdo/tap_tdo_en update on negedge from the post-posedge state:
  - in ShDR/ShIR: tdo = selected shift reg LSB, en=1;
  - otherwise: tdo=0, en=0.
- First bit on TDO is the captured LSB, valid at the negedge after the posedge entering ShDR/ShIR.
- N-bit register: N posedges in Shift (last with TMS=1 exiting to Ex1) shift in exactly N TDI bits.
- cfg_out changes at the posedge leaving UpdDR (state UpdDR active one cycle); stable otherwise.
- BYPASS: TDO = TDI delayed by one posedge plus half cycle.
- trst_n deassertion is taken synchronously to tap_tck by the integrator; this block only needs asynchronous assertion.
- PauseDR/PauseIR hold all shift contents indefinitely.

## Test plan
- Assert trst_n low mid-ShDR under CFG with cfg_out=0xA5A5A5A5 → immediately tap_state=F, tdo=0, tdo_en=0, cfg_out=CFG_RESET; then TLR→RTI→ShDR, shift 32 → TDO yields IDCODE_VAL LSB-first.
- IR scan shifting in 4'b0010 → TDO emits 1,0,0,0 (capture 0001); DR scan of 0xDEADBEEF → cfg_out=0xDEADBEEF one posedge after UpdDR; second scan returns 0xDEADBEEF on TDO.
- IR=STATUS, status_in=0x12345678 held through CapDR → TDO returns 0x12345678 LSB-first; UpdDR leaves cfg_out unchanged.
- IR=4'b0111 (undefined) → 1-bit bypass; shifting pattern 1,0,1,1 → TDO emits 0 then 1,0,1.
- With cfg_out=0xCAFEF00D, hold TMS=1 for 5 clocks from ShIR → tap_state=F, IR=IDCODE, cfg_out still 0xCAFEF00D.
- Pause check: enter PauseDR mid-CFG shift for 10 clocks, resume via Ex2DR → shifted-out/in data identical to an uninterrupted scan.
